dmem_arbiter: RTL and testbench

Two-requester arbiter that shares the single-port 256-word data memory between the pipeline MEM stage (CPU port) and a DMA/loader port. It sits between both requesters and the data memory: it selects one access per cycle, drives the memory's address/data/read/write controls, registers read data back to the winning requester, and stalls the loser. CPU has default priority. A starvation counter guarantees DMA progress, and a bounded burst mode lets DMA hold the memory for consecutive beats.

---
 rtl/dmem_pkg.sv | 20 ++
 rtl/dmem_arbiter.sv | 121 ++++++++++++
 tb/tb_dmem_arbiter.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared data-memory widths, arbiter state encoding and access payload.
package dmem_pkg;

    localparam int unsigned ADR_W    = 8;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned STARVE_W = 4;
    localparam int unsigned BEAT_W   = 8;

    typedef enum logic {
        ARB   = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic              we;
        logic [ADR_W-1:0]  adr;
        logic [DATA_W-1:0] wdata;
    } mem_acc_t;

endpackage

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the CPU MEM stage and the DMA port.
// CPU has default priority; a starvation counter and bounded DMA bursts guarantee progress.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4,
    parameter int unsigned BURST_MAX  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADR_W-1:0]  cpu_adr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_stall,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_rvalid,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADR_W-1:0]  dma_adr,
    input  logic [DATA_W-1:0] dma_wdata,
    input  logic              dma_burst,
    output logic              dma_gnt,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              dma_rvalid,
    output logic [ADR_W-1:0]  mem_adr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_w,
    output logic              mem_r,
    input  logic [DATA_W-1:0] mem_rdata
);

    arb_state_t          state;
    logic [STARVE_W-1:0] starve_cnt;
    logic [BEAT_W-1:0]   beat_cnt;
    mem_acc_t            cpu_acc;
    mem_acc_t            dma_acc;
    mem_acc_t            win_acc;
    logic                any_gnt;

    assign cpu_acc = '{we: cpu_we, adr: cpu_adr, wdata: cpu_wdata};
    assign dma_acc = '{we: dma_we, adr: dma_adr, wdata: dma_wdata};

    // Same-cycle grant decision; everything is held off while in reset.
    always_comb begin
        cpu_gnt = 1'b0;
        dma_gnt = 1'b0;
        if (rst_n) begin
            if (state == BURST) begin
                dma_gnt = dma_req;
            end else if (cpu_req && dma_req) begin
                if (starve_cnt < STARVE_W'(STARVE_MAX)) cpu_gnt = 1'b1;
                else                                    dma_gnt = 1'b1;
            end else begin
                cpu_gnt = cpu_req;
                dma_gnt = dma_req;
            end
        end
    end

    assign cpu_stall = rst_n & cpu_req & ~cpu_gnt;
    assign any_gnt   = cpu_gnt | dma_gnt;

    always_comb begin
        win_acc = '0;
        if (cpu_gnt)      win_acc = cpu_acc;
        else if (dma_gnt) win_acc = dma_acc;
    end

    assign mem_adr   = win_acc.adr;
    assign mem_wdata = win_acc.wdata;
    assign mem_w     = any_gnt & win_acc.we;
    assign mem_r     = any_gnt & ~win_acc.we;

    // Read return registers, starvation counter and burst tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ARB;
            starve_cnt <= '0;
            beat_cnt   <= '0;
            cpu_rdata  <= '0;
            cpu_rvalid <= 1'b0;
            dma_rdata  <= '0;
            dma_rvalid <= 1'b0;
        end else begin
            cpu_rvalid <= cpu_gnt & ~cpu_we;
            dma_rvalid <= dma_gnt & ~dma_we;
            if (cpu_gnt && !cpu_we) cpu_rdata <= mem_rdata;
            if (dma_gnt && !dma_we) dma_rdata <= mem_rdata;

            case (state)
                ARB: begin
                    if (dma_gnt || !dma_req) begin
                        starve_cnt <= '0;
                    end else if (cpu_gnt && starve_cnt != '1) begin
                        starve_cnt <= starve_cnt + STARVE_W'(1);
                    end
                    if (dma_gnt && dma_burst && BURST_MAX > 1) begin
                        state    <= BURST;
                        beat_cnt <= BEAT_W'(1);
                    end
                end
                BURST: begin
                    starve_cnt <= '0;
                    if (!dma_req || !dma_burst || beat_cnt == BEAT_W'(BURST_MAX - 1)) begin
                        state    <= ARB;
                        beat_cnt <= '0;
                    end else begin
                        beat_cnt <= beat_cnt + BEAT_W'(1);
                    end
                end
                default: begin
                    state    <= ARB;
                    beat_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized and directed bench for dmem_arbiter against a rule-level reference model.
module tb_dmem_arbiter;

    localparam int unsigned STARVE_MAX = 4;
    localparam int unsigned BURST_MAX  = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_req, cpu_we, cpu_gnt, cpu_stall, cpu_rvalid;
    logic [7:0]  cpu_adr;
    logic [31:0] cpu_wdata, cpu_rdata;
    logic        dma_req, dma_we, dma_burst, dma_gnt, dma_rvalid;
    logic [7:0]  dma_adr;
    logic [31:0] dma_wdata, dma_rdata;
    logic [7:0]  mem_adr;
    logic [31:0] mem_wdata, mem_rdata;
    logic        mem_w, mem_r;

    logic [31:0] tb_mem [256];
    logic        ld;
    logic [7:0]  ld_adr;
    logic [31:0] ld_data;

    dmem_arbiter #(.STARVE_MAX(STARVE_MAX), .BURST_MAX(BURST_MAX)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_adr(cpu_adr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
        .dma_req(dma_req), .dma_we(dma_we), .dma_adr(dma_adr), .dma_wdata(dma_wdata),
        .dma_burst(dma_burst), .dma_gnt(dma_gnt), .dma_rdata(dma_rdata), .dma_rvalid(dma_rvalid),
        .mem_adr(mem_adr), .mem_wdata(mem_wdata), .mem_w(mem_w), .mem_r(mem_r),
        .mem_rdata(mem_rdata)
    );

    initial forever #5 clk = ~clk;

    // Behavioural single-port memory; the loader only runs while the arbiter is in reset.
    always @(posedge clk) begin
        if (ld)         tb_mem[ld_adr]  <= ld_data;
        else if (mem_w) tb_mem[mem_adr] <= mem_wdata;
    end
    assign mem_rdata = tb_mem[mem_adr];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Reference model: burst flag, beats taken, lost-conflict count, expected read returns.
    logic [31:0] ref_mem [256];
    bit          m_burst;
    int          m_beats, m_starve;
    bit          e_crv, e_drv;
    logic [31:0] e_crd, e_drd;
    int          last_win;
    logic [1:0]  obs_gnt;

    task automatic model_reset();
        m_burst  = 0;
        m_beats  = 0;
        m_starve = 0;
        e_crv    = 0;
        e_drv    = 0;
        e_crd    = '0;
        e_drd    = '0;
    endtask

    // Called at a falling edge with inputs set; checks this cycle, advances one clock.
    task automatic cycle();
        int          win;
        logic        we;
        logic [7:0]  adr;
        logic [31:0] wd;
        #1;
        if (!rst_n) model_reset();
        win = 0;
        if (rst_n) begin
            if (m_burst)                 win = dma_req ? 2 : 0;
            else if (cpu_req && dma_req) win = (m_starve < STARVE_MAX) ? 1 : 2;
            else if (cpu_req)            win = 1;
            else if (dma_req)            win = 2;
        end
        we  = (win == 1) ? cpu_we    : dma_we;
        adr = (win == 1) ? cpu_adr   : dma_adr;
        wd  = (win == 1) ? cpu_wdata : dma_wdata;
        obs_gnt = {cpu_gnt, dma_gnt};
        check("cpu_gnt",    32'(cpu_gnt),   32'(win == 1));
        check("dma_gnt",    32'(dma_gnt),   32'(win == 2));
        check("cpu_stall",  32'(cpu_stall), 32'(rst_n && cpu_req && win != 1));
        check("mem_w",      32'(mem_w),     32'(win != 0 && we));
        check("mem_r",      32'(mem_r),     32'(win != 0 && !we));
        check("mem_adr",    32'(mem_adr),   (win != 0) ? 32'(adr) : 32'd0);
        check("mem_wdata",  mem_wdata,      (win != 0) ? wd : 32'd0);
        check("cpu_rvalid", 32'(cpu_rvalid), 32'(e_crv));
        check("cpu_rdata",  cpu_rdata,       e_crd);
        check("dma_rvalid", 32'(dma_rvalid), 32'(e_drv));
        check("dma_rdata",  dma_rdata,       e_drd);
        @(posedge clk);
        if (rst_n) begin
            e_crv = 0;
            e_drv = 0;
            if (win != 0 && we) begin
                ref_mem[adr] = wd;
            end else if (win == 1) begin
                e_crv = 1;
                e_crd = ref_mem[adr];
            end else if (win == 2) begin
                e_drv = 1;
                e_drd = ref_mem[adr];
            end
            if (dma_req && win == 1) m_starve = (m_starve < 15) ? m_starve + 1 : 15;
            else if (win == 2 || !dma_req) m_starve = 0;
            if (m_burst) begin
                if (win == 2) m_beats++;
                if (!dma_req || !dma_burst || m_beats == BURST_MAX) begin
                    m_burst  = 0;
                    m_starve = 0;
                end
            end else if (win == 2 && dma_burst && BURST_MAX > 1) begin
                m_burst = 1;
                m_beats = 1;
            end
        end else begin
            model_reset();
        end
        last_win = win;
        @(negedge clk);
    endtask

    task automatic rand_inputs();
        if (!cpu_req || last_win == 1) begin
            cpu_req   = ($urandom_range(0, 3) != 0);
            cpu_we    = 1'($urandom_range(0, 1));
            cpu_adr   = 8'($urandom_range(0, 15));
            cpu_wdata = $urandom;
        end
        if (!dma_req || last_win == 2) begin
            dma_req   = ($urandom_range(0, 3) != 0);
            dma_we    = 1'($urandom_range(0, 1));
            dma_adr   = 8'($urandom_range(0, 15));
            dma_wdata = $urandom;
        end
        if ($urandom_range(0, 9) == 0) dma_burst = ~dma_burst;
    endtask

    int          k;
    bit          cpu_done;
    logic [31:0] saved;
    logic [31:0] v;

    initial begin
        rst_n = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_adr = 8'h01; cpu_wdata = 32'h1111_1111;
        dma_req = 1'b1; dma_we = 1'b1; dma_adr = 8'h02; dma_wdata = 32'h2222_2222;
        dma_burst = 1'b1;
        ld = 1'b0; ld_adr = '0; ld_data = '0;
        last_win = 0;
        model_reset();
        @(negedge clk);

        // Reset holds all outputs low while the memory image is loaded.
        for (int i = 0; i < 256; i++) begin
            v = $urandom;
            ld = 1'b1; ld_adr = 8'(i); ld_data = v;
            ref_mem[i] = v;
            cycle();
        end
        ld = 1'b0;
        cpu_req = 1'b0; dma_req = 1'b0; dma_burst = 1'b0;
        rst_n = 1'b1;
        cycle();

        // CPU alone: write then read back the same address.
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_adr = 8'h10; cpu_wdata = 32'hDEAD_BEEF;
        cycle();
        cpu_we = 1'b0;
        cycle();
        cpu_req = 1'b0;
        #1;
        check("raw_cpu_rdata",  cpu_rdata, 32'hDEAD_BEEF);
        check("raw_cpu_rvalid", 32'(cpu_rvalid), 32'd1);
        check("raw_dma_rvalid", 32'(dma_rvalid), 32'd0);
        cycle();

        // Continuous conflict: CPU x STARVE_MAX then DMA, repeating.
        cpu_req = 1'b1; cpu_we = 1'b0; dma_req = 1'b1; dma_we = 1'b0; dma_burst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cpu_adr = 8'($urandom_range(0, 255));
            dma_adr = 8'($urandom_range(0, 255));
            #1;
            check("conflict_dma_gnt",   32'(dma_gnt),   32'(i % 5 == 4));
            check("conflict_cpu_stall", 32'(cpu_stall), 32'(i % 5 == 4));
            cycle();
        end
        cpu_req = 1'b0; dma_req = 1'b0;
        cycle();

        // Ten burst writes: eight beats, one CPU access, then a new burst.
        dma_we = 1'b1; dma_burst = 1'b1; k = 0; cpu_done = 0;
        for (int s = 0; s < 11; s++) begin
            dma_req   = (k < 10);
            dma_adr   = 8'(32'h20 + k);
            dma_wdata = 32'hB000_0000 + 32'(k);
            cpu_req   = (s >= 1) && !cpu_done;
            cpu_we    = 1'b0;
            cpu_adr   = 8'h05;
            cycle();
            check("burst_seq", 32'(obs_gnt), (s == 8) ? 32'd2 : 32'd1);
            if (obs_gnt[0]) k++;
            if (obs_gnt[1]) cpu_done = 1;
        end
        check("burst_beats_done", 32'(k), 32'd10);
        dma_req = 1'b0; cpu_req = 1'b0;
        cycle();
        for (int i = 0; i < 10; i++) check("burst_mem", tb_mem[8'h20 + i], 32'hB000_0000 + 32'(i));

        // Early exit: dma_burst low on the fourth beat hands the next cycle to the CPU.
        k = 0; cpu_done = 0;
        for (int s = 0; s < 5; s++) begin
            dma_req   = 1'b1;
            dma_we    = 1'b1;
            dma_adr   = 8'(32'h30 + k);
            dma_wdata = 32'hC000_0000 + 32'(k);
            dma_burst = (s < 3);
            cpu_req   = (s >= 1) && !cpu_done;
            cpu_we    = 1'b0;
            cpu_adr   = 8'h06;
            cycle();
            check("early_seq", 32'(obs_gnt), (s == 4) ? 32'd2 : 32'd1);
            if (obs_gnt[0]) k++;
            if (obs_gnt[1]) cpu_done = 1;
        end
        dma_req = 1'b0; cpu_req = 1'b0;
        cycle();

        // Randomized traffic on a small address window.
        last_win = 0;
        for (int n = 0; n < 3000; n++) begin
            rand_inputs();
            cycle();
        end
        cpu_req = 1'b0; dma_req = 1'b0;
        cycle();
        cycle();

        // Reset during the fifth beat of a burst.
        dma_req = 1'b1; dma_burst = 1'b1; dma_we = 1'b0;
        for (int i = 0; i < 4; i++) begin
            dma_adr = 8'(32'h40 + i);
            cycle();
            check("rst_pre_beat", 32'(obs_gnt), 32'd1);
        end
        saved = ref_mem[8'h44];
        dma_we = 1'b1; dma_adr = 8'h44; dma_wdata = 32'h5555_AAAA;
        rst_n = 1'b0;
        #1;
        check("rst_mem_w",      32'(mem_w),      32'd0);
        check("rst_dma_gnt",    32'(dma_gnt),    32'd0);
        check("rst_dma_rvalid", 32'(dma_rvalid), 32'd0);
        check("rst_dma_rdata",  dma_rdata,       32'd0);
        cycle();
        check("rst_mem_kept", tb_mem[8'h44], saved);
        rst_n = 1'b1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_adr = 8'h07;
        cycle();
        check("rst_arb_first", 32'(obs_gnt), 32'd2);
        cpu_req = 1'b0;
        cycle();
        dma_req = 1'b0;
        cycle();

        for (int i = 0; i < 256; i++) check("mem_final", tb_mem[i], ref_mem[i]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
